// File: rtl/tri_bus_pkg.sv
// Shared types and width helper for the tri-state bus driver.
package tri_bus_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    TURN  = 2'd2
  } state_e;

  function automatic int clog2_min1(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/tri_bus_turn_cnt.sv
// Loadable down-counter timing the bus turnaround; saturates at zero.
module tri_bus_turn_cnt #(
  parameter int CW = 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          load,
  input  logic          dec,
  input  logic [CW-1:0] load_val,
  output logic [CW-1:0] cnt,
  output logic          zero
);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (dec && (cnt_q != '0)) begin
      cnt_d = cnt_q - CW'(1);
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt  = cnt_q;
  assign zero = (cnt_q == '0);

endmodule

// File: rtl/tri_bus_driver.sv
// Fixed-priority arbiter that lets one requesting group drive a shared
// tri-state bus, with dead cycles inserted on every owner change.
module tri_bus_driver #(
  parameter int WIDTH  = 4,
  parameter int GROUPS = 2,
  parameter int TURN   = 1,
  localparam int OW    = tri_bus_pkg::clog2_min1(GROUPS)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [GROUPS-1:0]       g_n,
  input  logic [GROUPS*WIDTH-1:0] a,
  output tri   [WIDTH-1:0]        y,
  output logic [OW-1:0]           owner,
  output logic                    busy,
  output logic                    contention
);

  import tri_bus_pkg::*;

  localparam int CW = clog2_min1(TURN + 1);

  state_e            state_q, state_d;
  logic [OW-1:0]     owner_q, owner_d, winner;
  logic [WIDTH-1:0]  data_q, data_d, a_owner, a_winner;
  logic              contention_q, contention_d;
  logic [GROUPS-1:0] req;
  logic              any_req, owner_req, leave, turn_last, drive_en;
  logic              cnt_load, cnt_dec, cnt_zero;
  logic [CW-1:0]     cnt;

  assign req = ~g_n;

  // Lowest index wins: scan downward so the last hit is the smallest.
  always_comb begin
    winner  = '0;
    any_req = 1'b0;
    for (int i = GROUPS - 1; i >= 0; i--) begin
      if (req[i]) begin
        winner  = OW'(i);
        any_req = 1'b1;
      end
    end
  end

  always_comb begin
    a_owner   = '0;
    a_winner  = '0;
    owner_req = 1'b0;
    for (int i = 0; i < GROUPS; i++) begin
      if (owner_q == OW'(i)) begin
        a_owner   = a[i*WIDTH +: WIDTH];
        owner_req = req[i];
      end
      if (winner == OW'(i)) begin
        a_winner = a[i*WIDTH +: WIDTH];
      end
    end
  end

  assign leave        = !owner_req || (any_req && (winner < owner_q));
  assign turn_last    = (cnt == CW'(1)) || cnt_zero;
  assign contention_d = |(req & (req - GROUPS'(1)));

  tri_bus_turn_cnt #(.CW(CW)) u_turn_cnt (
    .clk      (clk),
    .rst      (rst),
    .load     (cnt_load),
    .dec      (cnt_dec),
    .load_val (CW'(TURN)),
    .cnt      (cnt),
    .zero     (cnt_zero)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= tri_bus_pkg::IDLE;
      owner_q      <= '0;
      data_q       <= '0;
      contention_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      data_q       <= data_d;
      contention_q <= contention_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    owner_d  = owner_q;
    data_d   = data_q;
    cnt_load = 1'b0;
    cnt_dec  = 1'b0;
    case (state_q)
      tri_bus_pkg::IDLE: begin
        if (any_req) begin
          state_d = tri_bus_pkg::DRIVE;
          owner_d = winner;
          data_d  = a_winner;
        end
      end
      tri_bus_pkg::DRIVE: begin
        if (!leave) begin
          data_d = a_owner;
        end else if (TURN != 0) begin
          state_d  = tri_bus_pkg::TURN;
          cnt_load = 1'b1;
        end else if (any_req) begin
          owner_d = winner;
          data_d  = a_winner;
        end else begin
          state_d = tri_bus_pkg::IDLE;
        end
      end
      tri_bus_pkg::TURN: begin
        // Requests are only looked at on the final turnaround edge.
        cnt_dec = 1'b1;
        if (turn_last) begin
          if (any_req) begin
            state_d = tri_bus_pkg::DRIVE;
            owner_d = winner;
            data_d  = a_winner;
          end else begin
            state_d = tri_bus_pkg::IDLE;
          end
        end
      end
      default: state_d = tri_bus_pkg::IDLE;
    endcase
  end

  always_comb begin
    drive_en   = (state_q == tri_bus_pkg::DRIVE);
    busy       = drive_en;
    owner      = owner_q;
    contention = contention_q;
  end

  assign y = drive_en ? data_q : {WIDTH{1'bz}};

endmodule

// File: doc/tri_bus_driver.md
TRI_BUS_DRIVER -- requirements
Module: tri_bus_driver

Interface
REQ-001 Parameter WIDTH, default 4, meaning bits per group and width of the shared output bus.
REQ-002 Parameter GROUPS, default 2, meaning number of requesting input groups (2..8).
REQ-003 Parameter TURN, default 1, meaning dead (high-impedance) cycles inserted on every owner change (0..7).
REQ-004 clk  input  1  meaning the single clock; all state changes on its rising edge.
REQ-005 rst  input  1  meaning reset; asynchronous and active-high.
REQ-006 g_n  input  GROUPS  meaning per-group active-low drive requests; bit i belongs to group i.
REQ-007 a  input  GROUPS*WIDTH  meaning group data; group i occupies bits [i*WIDTH +: WIDTH].
REQ-008 y  output (tri-state)  WIDTH  meaning shared bus; driven only in DRIVE, otherwise all-Z.
REQ-009 owner  output  clog2(GROUPS), min 1  meaning index of the group currently driving y.
REQ-010 busy  output  1  meaning high while in DRIVE.
REQ-011 contention  output  1  meaning registered flag; high for each cycle following a clock edge at which two or more g_n bits were low.

Function
REQ-012 Priority SHALL be fixed: the lowest-index group with g_n low wins.
REQ-013 The FSM SHALL have states IDLE, DRIVE and TURN.
REQ-014 IDLE: y all-Z, busy 0; any request at an edge -> DRIVE with owner = winner and data register = winner's a; latency one cycle from request to valid y.
REQ-015 DRIVE: y = data register, busy 1; the data register reloads from owner's a every edge (one-cycle latency).
REQ-016 DRIVE exit: the owner's g_n high, or a higher-priority group requesting, at an edge -> TURN with counter = TURN, y Z.
REQ-017 TURN: y all-Z, busy 0, owner held; the counter decrements each edge.
REQ-018 TURN exit: counter reaching 0 -> DRIVE with the current winner loaded, or IDLE if no request.
REQ-019 TURN=0: the owner SHALL switch directly DRIVE->DRIVE with no Z cycle; release with no request -> IDLE.
REQ-020 A request appearing and vanishing entirely within TURN SHALL be ignored.
REQ-021 The owner re-requesting during TURN SHALL NOT shorten TURN.
REQ-022 contention SHALL be set from the g_n population count (more than one low) independent of FSM state.
REQ-023 The counter SHALL be clog2(TURN+1) bits wide, min 1, and SHALL never wrap below 0.

Reset
REQ-024 While rst is high, regardless of clk: state IDLE, y all-Z, owner 0, busy 0, contention 0, data register 0, counter 0.
REQ-025 Reset asserted mid-DRIVE or mid-TURN SHALL release y to Z immediately (asynchronously).
REQ-026 On the first edge after rst falls, the FSM SHALL follow REQ-014 normally.

Structure
REQ-027 Package tri_bus_pkg SHALL hold the state enum (IDLE, DRIVE, TURN) and a clog2-based width helper constant function.
REQ-028 Sub-module tri_bus_turn_cnt SHALL implement the loadable down-counter with a zero flag, reset asynchronously by rst.
REQ-029 The priority encoder and the tri-state output assignment SHALL reside in tri_bus_driver.

Verification (WIDTH=4, GROUPS=2, TURN=1 unless noted)
REQ-030 Assert rst with g_n=2'b00 -> y=4'bzzzz, busy=0, owner=0, contention=0 throughout.
REQ-031 g_n=2'b10, a0=4'hA -> next edge y=4'hA, owner=0, busy=1; set a0=4'h5 -> y=4'h5 one edge later.
REQ-032 Group 0 driving, then g_n=2'b11 -> next edge y=zzzz (TURN), following edge IDLE, y stays zzzz.
REQ-033 Group 1 driving a1=4'h3, then g_n=2'b00 with a0=4'hC -> contention=1, one Z cycle, then y=4'hC, owner=0.
REQ-034 rst pulsed between edges while y=4'hA -> y=zzzz immediately, busy=0 before the next edge.
REQ-035 TURN=0, group 1 driving 4'h3, group 0 requests 4'hC -> next edge y=4'hC, owner=0, no Z cycle.
